// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_seq
//  Purpose  : Hardwired T-state micro-sequencer for the 8-bit CPU model.
//             Fetches via T0..T3, then executes by opcode in T4..T7.
//             Control outputs are registered Moore outputs of the state.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_ctrl_seq #(
  parameter int OPW   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPW-1:0]   ir_op,
  output logic             EPC,
  output logic             IPC,
  output logic             LPC,
  output logic             IMAR,
  output logic             RD,
  output logic             WR,
  output logic             IDR,
  output logic             EDR,
  output logic             IIR,
  output logic             EIR,
  output logic             IA,
  output logic             EA,
  output logic             IB,
  output logic             EALU,
  output logic             SUB,
  output logic             IOUT,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_t;

  // Bit positions inside the packed control word
  localparam int c_EPC  = 0;
  localparam int c_IPC  = 1;
  localparam int c_LPC  = 2;
  localparam int c_IMAR = 3;
  localparam int c_RD   = 4;
  localparam int c_WR   = 5;
  localparam int c_IDR  = 6;
  localparam int c_EDR  = 7;
  localparam int c_IIR  = 8;
  localparam int c_EIR  = 9;
  localparam int c_IA   = 10;
  localparam int c_EA   = 11;
  localparam int c_IB   = 12;
  localparam int c_EALU = 13;
  localparam int c_SUB  = 14;
  localparam int c_IOUT = 15;

  localparam logic [OPW-1:0] c_OP_LDA = OPW'(0);
  localparam logic [OPW-1:0] c_OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] c_OP_SBT = OPW'(2);
  localparam logic [OPW-1:0] c_OP_STA = OPW'(3);
  localparam logic [OPW-1:0] c_OP_OUT = OPW'(4);
  localparam logic [OPW-1:0] c_OP_JMP = OPW'(5);
  localparam logic [OPW-1:0] c_OP_HLT = OPW'(15);

  state_t           r_state;
  logic [OPW-1:0]   r_op;
  logic [15:0]      r_ctrl;
  state_t           w_nxt_state;
  logic [OPW-1:0]   w_nxt_op;
  logic             w_last;
  logic             w_retire;
  state_t           w_boundary;

  // Control word asserted while sitting in state s with latched opcode op
  function automatic logic [15:0] ctrl_of(state_t s, logic [OPW-1:0] op);
    logic [15:0] c;
    c = '0;
    case (s)
      S_T0: begin c[c_EPC] = 1'b1; c[c_IMAR] = 1'b1; end
      S_T1: c[c_IPC] = 1'b1;
      S_T2: begin c[c_RD]  = 1'b1; c[c_IDR]  = 1'b1; end
      S_T3: begin c[c_EDR] = 1'b1; c[c_IIR]  = 1'b1; end
      S_T4: begin
        if (op == c_OP_LDA || op == c_OP_ADD || op == c_OP_SBT || op == c_OP_STA) begin
          c[c_EIR] = 1'b1; c[c_IMAR] = 1'b1;
        end else if (op == c_OP_OUT) begin
          c[c_EA] = 1'b1; c[c_IOUT] = 1'b1;
        end else if (op == c_OP_JMP) begin
          c[c_EIR] = 1'b1; c[c_LPC] = 1'b1;
        end
      end
      S_T5: begin
        if (op == c_OP_LDA || op == c_OP_ADD || op == c_OP_SBT) begin
          c[c_RD] = 1'b1; c[c_IDR] = 1'b1;
        end else if (op == c_OP_STA) begin
          c[c_EA] = 1'b1; c[c_IDR] = 1'b1;
        end
      end
      S_T6: begin
        if (op == c_OP_LDA) begin
          c[c_EDR] = 1'b1; c[c_IA] = 1'b1;
        end else if (op == c_OP_ADD || op == c_OP_SBT) begin
          c[c_EDR] = 1'b1; c[c_IB] = 1'b1;
        end else if (op == c_OP_STA) begin
          c[c_EDR] = 1'b1; c[c_WR] = 1'b1;
        end
      end
      S_T7: begin
        if (op == c_OP_ADD || op == c_OP_SBT) begin
          c[c_EALU] = 1'b1; c[c_IA] = 1'b1;
          c[c_SUB]  = (op == c_OP_SBT);
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // True when state s is the final step of opcode op (HLT/NOP/OUT/JMP end at T4)
  function automatic logic is_last(state_t s, logic [OPW-1:0] op);
    logic mem_op;
    mem_op = (op == c_OP_LDA || op == c_OP_ADD || op == c_OP_SBT || op == c_OP_STA);
    case (s)
      S_T4:    return !mem_op;
      S_T6:    return (op == c_OP_LDA || op == c_OP_STA);
      S_T7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Next-state, opcode latch and retirement decision
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op;
    w_last      = is_last(r_state, r_op);
    w_retire    = 1'b0;
    w_boundary  = run ? S_T0 : S_IDLE;
    case (r_state)
      S_IDLE: w_nxt_state = run ? S_T0 : S_IDLE;
      S_T0:   w_nxt_state = S_T1;
      S_T1:   w_nxt_state = S_T2;
      S_T2:   w_nxt_state = S_T3;
      S_T3: begin
        w_nxt_state = S_T4;
        w_nxt_op    = ir_op;
      end
      S_T4: begin
        w_retire = w_last;
        if (r_op == c_OP_HLT) w_nxt_state = S_HALT;
        else                  w_nxt_state = w_last ? w_boundary : S_T5;
      end
      S_T5: w_nxt_state = S_T6;
      S_T6: begin
        w_retire    = w_last;
        w_nxt_state = w_last ? w_boundary : S_T7;
      end
      S_T7: begin
        w_retire    = 1'b1;
        w_nxt_state = w_boundary;
      end
      S_HALT:  w_nxt_state = S_HALT;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Sequencer state, registered controls, halt flag and retirement counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_ctrl    <= '0;
      halted    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_op    <= w_nxt_op;
      r_ctrl  <= ctrl_of(w_nxt_state, w_nxt_op);
      halted  <= (w_nxt_state == S_HALT);
      if (w_retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign EPC  = r_ctrl[c_EPC];
  assign IPC  = r_ctrl[c_IPC];
  assign LPC  = r_ctrl[c_LPC];
  assign IMAR = r_ctrl[c_IMAR];
  assign RD   = r_ctrl[c_RD];
  assign WR   = r_ctrl[c_WR];
  assign IDR  = r_ctrl[c_IDR];
  assign EDR  = r_ctrl[c_EDR];
  assign IIR  = r_ctrl[c_IIR];
  assign EIR  = r_ctrl[c_EIR];
  assign IA   = r_ctrl[c_IA];
  assign EA   = r_ctrl[c_EA];
  assign IB   = r_ctrl[c_IB];
  assign EALU = r_ctrl[c_EALU];
  assign SUB  = r_ctrl[c_SUB];
  assign IOUT = r_ctrl[c_IOUT];

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_ctrl_seq
//  Purpose  : Self-checking bench for cpu_ctrl_seq with an instruction-level
//             reference model, directed pins and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] ir_op;
  logic EPC, IPC, LPC, IMAR, RD, WR, IDR, EDR, IIR, EIR, IA, EA, IB, EALU, SUB, IOUT;
  logic       halted;
  logic [7:0] instr_cnt;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  // Bench-side control masks, order {EPC,IPC,LPC,IMAR,RD,WR,IDR,EDR,IIR,EIR,IA,EA,IB,EALU,SUB,IOUT}
  localparam logic [15:0] M_EPC  = 16'h8000, M_IPC = 16'h4000, M_LPC = 16'h2000, M_IMAR = 16'h1000;
  localparam logic [15:0] M_RD   = 16'h0800, M_WR  = 16'h0400, M_IDR = 16'h0200, M_EDR  = 16'h0100;
  localparam logic [15:0] M_IIR  = 16'h0080, M_EIR = 16'h0040, M_IA  = 16'h0020, M_EA   = 16'h0010;
  localparam logic [15:0] M_IB   = 16'h0008, M_EALU= 16'h0004, M_SUB = 16'h0002, M_IOUT = 16'h0001;

  cpu_ctrl_seq #(.OPW(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir_op(ir_op),
    .EPC(EPC), .IPC(IPC), .LPC(LPC), .IMAR(IMAR), .RD(RD), .WR(WR),
    .IDR(IDR), .EDR(EDR), .IIR(IIR), .EIR(EIR), .IA(IA), .EA(EA),
    .IB(IB), .EALU(EALU), .SUB(SUB), .IOUT(IOUT),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  wire [15:0] dutv = {EPC, IPC, LPC, IMAR, RD, WR, IDR, EDR, IIR, EIR, IA, EA, IB, EALU, SUB, IOUT};

  // ---------------- reference model: instruction = fetch list + exec list ----
  function automatic int exec_len(logic [3:0] op);
    case (op)
      4'h0, 4'h3: return 3;
      4'h1, 4'h2: return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [15:0] fetch_ctrl(int k);
    case (k)
      0: return M_EPC | M_IMAR;
      1: return M_IPC;
      2: return M_RD | M_IDR;
      default: return M_EDR | M_IIR;
    endcase
  endfunction

  function automatic logic [15:0] exec_ctrl(logic [3:0] op, int k);
    logic [15:0] lda[3], add[4], sta[3];
    lda = '{M_EIR | M_IMAR, M_RD | M_IDR, M_EDR | M_IA};
    add = '{M_EIR | M_IMAR, M_RD | M_IDR, M_EDR | M_IB, M_EALU | M_IA};
    sta = '{M_EIR | M_IMAR, M_EA | M_IDR, M_EDR | M_WR};
    case (op)
      4'h0: return lda[k];
      4'h1: return add[k];
      4'h2: return (k == 3) ? (add[k] | M_SUB) : add[k];
      4'h3: return sta[k];
      4'h4: return M_EA | M_IOUT;
      4'h5: return M_EIR | M_LPC;
      default: return 16'h0000;
    endcase
  endfunction

  int         m_pos;   // -1 idle, 0..3 fetch step, 4.. execute step
  logic [3:0] m_op;
  logic [7:0] m_cnt;
  bit         m_halt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= -1; m_op <= 4'h0; m_cnt <= 8'h00; m_halt <= 1'b0;
    end else if (m_halt) begin
      m_pos <= m_pos;
    end else if (m_pos < 0) begin
      if (run) m_pos <= 0;
    end else if (m_pos < 4) begin
      if (m_pos == 3) m_op <= ir_op;
      m_pos <= m_pos + 1;
    end else if (m_pos - 4 == exec_len(m_op) - 1) begin
      m_cnt <= m_cnt + 8'd1;
      if (m_op == 4'hF) m_halt <= 1'b1;
      else              m_pos  <= run ? 0 : -1;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic logic [15:0] model_ctrl();
    if (m_halt || m_pos < 0) return 16'h0000;
    if (m_pos < 4)           return fetch_ctrl(m_pos);
    return exec_ctrl(m_op, m_pos - 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model plus structural invariants
  always @(negedge clk) begin
    if (checking) begin
      chk("ctrl", {16'h0, dutv}, {16'h0, model_ctrl()});
      chk("halted", {31'h0, halted}, {31'h0, m_halt});
      chk("instr_cnt", {24'h0, instr_cnt}, {24'h0, m_cnt});
      chk("bus_drivers_le1", {31'h0, ($countones({EPC, EDR, EIR, EA, EALU}) <= 1)}, 32'h1);
      chk("rd_wr_excl", {31'h0, (RD & WR)}, 32'h0);
    end
  end

  // Asynchronous reset pulse inside the current cycle, checked while held
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {16'h0, dutv}, 32'h0);
    chk("async_rst_halted", {31'h0, halted}, 32'h0);
    chk("async_rst_cnt", {24'h0, instr_cnt}, 32'h0);
    #1 rst_n = 1'b1;
  endtask

  logic [15:0] lda_seq[7];
  int          hcnt;

  initial begin
    lda_seq = '{M_EPC | M_IMAR, M_IPC, M_RD | M_IDR, M_EDR | M_IIR,
                M_EIR | M_IMAR, M_RD | M_IDR, M_EDR | M_IA};
    rst_n = 1'b0; run = 1'b0; ir_op = 4'h0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1; checking = 1'b1;

    // Reset state, idle with run low
    @(negedge clk);
    chk("reset_ctrl", {16'h0, dutv}, 32'h0);
    chk("reset_cnt", {24'h0, instr_cnt}, 32'h0);
    chk("reset_halted", {31'h0, halted}, 32'h0);
    run = 1'b1; ir_op = 4'h0;

    // LDA through T0..T6; opcode churn after T4 must be ignored
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("lda_T%0d", i), {16'h0, dutv}, {16'h0, lda_seq[i]});
      if (i == 5) ir_op = 4'h9;
      if (i == 6) ir_op = 4'h2;
    end
    @(negedge clk);
    chk("lda_next_T0", {16'h0, dutv}, {16'h0, M_EPC | M_IMAR});
    chk("lda_cnt", {24'h0, instr_cnt}, 32'h1);
    chk("model_cnt_pin", {24'h0, m_cnt}, 32'h1);

    // SUBT: T7 shows EALU+IA+SUB, run dropped at T7 -> IDLE
    repeat (7) @(negedge clk);
    chk("subt_T7", {16'h0, dutv}, {16'h0, M_EALU | M_IA | M_SUB});
    run = 1'b0;
    @(negedge clk);
    chk("idle_after_subt", {16'h0, dutv}, 32'h0);
    chk("subt_cnt", {24'h0, instr_cnt}, 32'h2);

    // HLT: halts, counts once, ignores run
    run = 1'b1; ir_op = 4'hF;
    repeat (6) @(negedge clk);
    chk("hlt_halted", {31'h0, halted}, 32'h1);
    chk("hlt_cnt", {24'h0, instr_cnt}, 32'h3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
    end
    chk("hlt_hold", {31'h0, halted}, 32'h1);
    chk("hlt_hold_cnt", {24'h0, instr_cnt}, 32'h3);
    pulse_reset();

    // Counter wrap: 260 NOPs of 5 cycles each
    @(negedge clk);
    run = 1'b1; ir_op = 4'h6;
    repeat (260 * 5 + 3) @(negedge clk);

    // Randomized traffic with occasional mid-T2 resets and halt recovery
    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      run   = ($urandom_range(0, 7) != 0);
      ir_op = 4'($urandom_range(0, 15));
      if (m_halt) begin
        hcnt++;
        if (hcnt > 20) begin hcnt = 0; pulse_reset(); end
      end else if (m_pos == 2 && $urandom_range(0, 9) == 0) begin
        pulse_reset();
      end
    end

    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
